tone_sweep_ctrl: RTL and testbench

Synthesizable sequencer that drives the NCO/tone datapath through a stepped frequency sweep.
- Loads a shadow copy of the sweep configuration, then issues frequency tuning words (FTW) to the NCO, each held for a programmed dwell time.
- Ramps tone amplitude up at sweep start and down at sweep end.
- Sits between the register bank and the NCO; replaces hand-driven phase-increment updates in bench and radio bring-up.

---
 rtl/tone_sweep_pkg.sv | 32 +++
 rtl/sweep_ampl_ramp.sv | 34 +++
 rtl/tone_sweep_ctrl.sv | 137 +++++++++++++
 tb/tb_tone_sweep_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_sweep_pkg.sv
// tone_sweep_pkg: shared types and default widths for the stepped tone sweep sequencer.
package tone_sweep_pkg;

    localparam int FTW_W     = 32;
    localparam int DWELL_W   = 24;
    localparam int NSTEP_W   = 16;
    localparam int AMPL_W    = 16;
    localparam int RAMP_STEP = 256;

    typedef enum logic [2:0] {
        IDLE,
        RAMP_UP,
        DWELL,
        RAMP_DOWN,
        FINISH
    } sweep_state_t;

    typedef struct packed {
        logic [FTW_W-1:0]   start_ftw;
        logic [FTW_W-1:0]   step_ftw;
        logic [NSTEP_W-1:0] num_steps;
        logic [DWELL_W-1:0] dwell;
        logic [AMPL_W-1:0]  ampl;
        logic               loop;
    } sweep_cfg_t;

    // A dwell of 0 behaves as 1, so the reload value is max(d,1)-1.
    function automatic logic [DWELL_W-1:0] dwell_reload(input logic [DWELL_W-1:0] d);
        return (d == '0) ? '0 : d - 1'b1;
    endfunction

endpackage

// File: rtl/sweep_ampl_ramp.sv
// sweep_ampl_ramp: saturating linear amplitude ramp toward a target (up) or toward zero (down).
module sweep_ampl_ramp #(
    parameter int AMPL_W    = tone_sweep_pkg::AMPL_W,
    parameter int RAMP_STEP = tone_sweep_pkg::RAMP_STEP
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_up,
    input  logic              i_down,
    input  logic [AMPL_W-1:0] i_target,
    output logic [AMPL_W-1:0] o_ampl,
    output logic              o_at_target
);

    localparam logic [AMPL_W-1:0] STEP = AMPL_W'(RAMP_STEP);

    logic [AMPL_W-1:0] r_ampl;
    logic [AMPL_W-1:0] w_next;

    assign w_next = i_up   ? ((r_ampl >= i_target || i_target - r_ampl <= STEP) ? i_target : r_ampl + STEP) :
                    i_down ? ((r_ampl <= STEP) ? '0 : r_ampl - STEP) :
                    r_ampl;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_ampl <= '0;
        else
            r_ampl <= w_next;
    end

    assign o_ampl      = r_ampl;
    assign o_at_target = (r_ampl == i_target);

endmodule

// File: rtl/tone_sweep_ctrl.sv
// tone_sweep_ctrl: drives the NCO through a stepped FTW sweep with a programmable dwell per tone.
// Define TONE_SWEEP_RAMP_EN for linear amplitude ramps; otherwise the amplitude switches hard.
module tone_sweep_ctrl #(
    parameter int FTW_W   = tone_sweep_pkg::FTW_W,
    parameter int DWELL_W = tone_sweep_pkg::DWELL_W,
    parameter int NSTEP_W = tone_sweep_pkg::NSTEP_W,
    parameter int AMPL_W  = tone_sweep_pkg::AMPL_W
`ifdef TONE_SWEEP_RAMP_EN
    ,
    parameter int RAMP_STEP = tone_sweep_pkg::RAMP_STEP
`endif
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [FTW_W-1:0]   cfg_start_ftw,
    input  logic [FTW_W-1:0]   cfg_step_ftw,
    input  logic [NSTEP_W-1:0] cfg_num_steps,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [AMPL_W-1:0]  cfg_ampl,
    input  logic               cfg_loop,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic [FTW_W-1:0]   ftw_out,
    output logic               ftw_valid,
    output logic               phase_clr,
    output logic [AMPL_W-1:0]  ampl_out,
    output logic [NSTEP_W-1:0] step_idx
);

    import tone_sweep_pkg::*;

    sweep_state_t       r_state;
    sweep_state_t       w_next;
    sweep_cfg_t         r_cfg;
    logic [FTW_W-1:0]   r_ftw;
    logic [NSTEP_W-1:0] r_step_idx;
    logic [DWELL_W-1:0] r_dwell;
    logic               r_ftw_valid;
    logic               r_phase_clr;
    logic               w_start;
    logic               w_expire;
    logic               w_last;
    logic               w_step;
    logic               w_up_done;
    logic               w_down_done;

`ifdef TONE_SWEEP_RAMP_EN
    localparam sweep_state_t S_RUN = RAMP_UP;
    localparam sweep_state_t S_END = RAMP_DOWN;

    sweep_ampl_ramp #(
        .AMPL_W    (AMPL_W),
        .RAMP_STEP (RAMP_STEP)
    ) u_ramp (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_up        (r_state == RAMP_UP),
        .i_down      (r_state == RAMP_DOWN),
        .i_target    (r_cfg.ampl),
        .o_ampl      (ampl_out),
        .o_at_target (w_up_done)
    );

    assign w_down_done = (ampl_out == '0);
`else
    localparam sweep_state_t S_RUN = DWELL;
    localparam sweep_state_t S_END = FINISH;

    assign w_up_done   = 1'b1;
    assign w_down_done = 1'b1;
    assign ampl_out    = (r_state == DWELL) ? r_cfg.ampl : '0;
`endif

    assign w_start  = (r_state == IDLE) && start && !abort;
    // Expiry is acted on only in DWELL, so a dwell that runs out during the ramp steps on the first DWELL cycle.
    assign w_expire = (r_state == DWELL) && (r_dwell == '0) && !abort;
    assign w_last   = (r_step_idx == r_cfg.num_steps);
    assign w_step   = w_expire && (!w_last || r_cfg.loop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      w_next = w_start ? S_RUN : IDLE;
            RAMP_UP:   w_next = abort ? S_END : (w_up_done ? DWELL : RAMP_UP);
            DWELL:     w_next = (abort || (w_expire && !w_step)) ? S_END : DWELL;
            RAMP_DOWN: w_next = w_down_done ? FINISH : RAMP_DOWN;
            default:   w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != IDLE);
        done = (r_state == FINISH);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cfg       <= '0;
            r_ftw       <= '0;
            r_step_idx  <= '0;
            r_dwell     <= '0;
            r_ftw_valid <= 1'b0;
            r_phase_clr <= 1'b0;
        end else begin
            r_ftw_valid <= w_start || w_step;
            r_phase_clr <= w_start;
            if (w_start) begin
                r_cfg      <= '{start_ftw: cfg_start_ftw, step_ftw: cfg_step_ftw, num_steps: cfg_num_steps,
                                dwell: cfg_dwell, ampl: cfg_ampl, loop: cfg_loop};
                r_ftw      <= cfg_start_ftw;
                r_step_idx <= '0;
                r_dwell    <= dwell_reload(cfg_dwell);
            end else if (w_step) begin
                r_ftw      <= w_last ? r_cfg.start_ftw : r_ftw + r_cfg.step_ftw;
                r_step_idx <= w_last ? '0 : r_step_idx + 1'b1;
                r_dwell    <= dwell_reload(r_cfg.dwell);
            end else if (r_dwell != '0 && (r_state == RAMP_UP || r_state == DWELL)) begin
                r_dwell    <= r_dwell - 1'b1;
            end
        end
    end

    assign ftw_out   = r_ftw;
    assign ftw_valid = r_ftw_valid;
    assign phase_clr = r_phase_clr;
    assign step_idx  = r_step_idx;

endmodule

// File: tb/tb_tone_sweep_ctrl.sv
// tb_tone_sweep_ctrl: directed vector bench for tone_sweep_ctrl; expectations follow TONE_SWEEP_RAMP_EN.
module tb_tone_sweep_ctrl;

`ifdef TONE_SWEEP_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] cfg_start_ftw = '0;
    logic [31:0] cfg_step_ftw = '0;
    logic [15:0] cfg_num_steps = '0;
    logic [23:0] cfg_dwell = '0;
    logic [15:0] cfg_ampl = '0;
    logic        cfg_loop = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] ftw_out;
    logic        ftw_valid;
    logic        phase_clr;
    logic [15:0] ampl_out;
    logic [15:0] step_idx;

    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] start_ftw;
        logic [31:0] step_ftw;
        logic [15:0] nsteps;
        logic [23:0] dwell;
        logic [15:0] ampl;
        logic [31:0] exp_second;
        logic [31:0] exp_last;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    tone_sweep_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cfg_start_ftw (cfg_start_ftw),
        .cfg_step_ftw  (cfg_step_ftw),
        .cfg_num_steps (cfg_num_steps),
        .cfg_dwell     (cfg_dwell),
        .cfg_ampl      (cfg_ampl),
        .cfg_loop      (cfg_loop),
        .start         (start),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .ftw_out       (ftw_out),
        .ftw_valid     (ftw_valid),
        .phase_clr     (phase_clr),
        .ampl_out      (ampl_out),
        .step_idx      (step_idx)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Cycles spent ramping from 0 to a (or back) including the cycle at the end value.
    function automatic int ramp_len(input int a);
        return RAMP ? (a + 255) / 256 + 1 : 0;
    endfunction

    task automatic set_cfg(input vec_t v, input logic loop);
        cfg_start_ftw = v.start_ftw;
        cfg_step_ftw  = v.step_ftw;
        cfg_num_steps = v.nsteps;
        cfg_dwell     = v.dwell;
        cfg_ampl      = v.ampl;
        cfg_loop      = loop;
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] ftws[$];
        int          times[$];
        int          idx_err = 0;
        int          int_err = 0;
        int          pclr = 0;
        int          done_at = -1;
        int          maxa = 0;
        int          de;
        int          l0;
        logic [15:0] a0 = '0;
        set_cfg(v, 1'b0);
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 0) a0 = ampl_out;
            if (int'(ampl_out) > maxa) maxa = int'(ampl_out);
            if (phase_clr) pclr++;
            if (ftw_valid) begin
                if (int'(step_idx) != ftws.size()) idx_err++;
                ftws.push_back(ftw_out);
                times.push_back(cyc);
            end
            if (done) begin
                done_at = cyc;
                break;
            end
        end
        de = (v.dwell == 0) ? 1 : int'(v.dwell);
        l0 = (ramp_len(int'(v.ampl)) + 1 > de) ? ramp_len(int'(v.ampl)) + 1 : de;
        for (int i = 1; i < times.size(); i++)
            if (times[i] - times[i-1] != ((i == 1) ? l0 : de)) int_err++;
        check("valid_count", ftws.size(), int'(v.nsteps) + 1);
        check("first_ftw", (ftws.size() > 0) ? ftws[0] : 32'hxxxx_xxxx, v.start_ftw);
        if (v.nsteps > 0)
            check("second_ftw", (ftws.size() > 1) ? ftws[1] : 32'hxxxx_xxxx, v.exp_second);
        check("last_ftw", (ftws.size() > 0) ? ftws[ftws.size()-1] : 32'hxxxx_xxxx, v.exp_last);
        check("step_idx_seq", idx_err, 0);
        check("tone_intervals", int_err, 0);
        check("done_cycle", done_at, l0 + int'(v.nsteps) * de + ramp_len(int'(v.ampl)));
        check("phase_clr_count", pclr, 1);
        check("ampl_first", a0, RAMP ? 16'd0 : v.ampl);
        check("ampl_peak", maxa, v.ampl);
        @(negedge clk);
        check("busy_after_done", busy, 0);
        check("done_width", done, 0);
        check("ftw_held", ftw_out, v.exp_last);
        check("ampl_after_done", ampl_out, 0);
    endtask

    task automatic run_loop_abort();
        int          nv = 0;
        int          err = 0;
        int          pclr = 0;
        int          last_t = 0;
        int          after = 0;
        int          done_idx = -1;
        logic [15:0] ampl_done = '1;
        cfg_start_ftw = 32'h0000_2000;
        cfg_step_ftw  = 32'h0000_1000;
        cfg_num_steps = 16'd1;
        cfg_dwell     = 24'd4;
        cfg_ampl      = 16'd256;
        cfg_loop      = 1'b1;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 0; cyc < 100 && nv < 5; cyc++) begin
            @(negedge clk);
            start = (cyc == 7);
            cfg_start_ftw = 32'hDEAD_0000;
            if (phase_clr) pclr++;
            if (ftw_valid) begin
                if (ftw_out !== ((nv % 2 == 0) ? 32'h0000_2000 : 32'h0000_3000)) err++;
                if (step_idx !== 16'(nv % 2)) err++;
                if (nv > 0 && cyc - last_t != 4) err++;
                last_t = cyc;
                nv++;
            end
        end
        start = 1'b0;
        check("loop_ftw_seq", err, 0);
        check("loop_valid_count", nv, 5);
        check("loop_phase_clr", pclr, 1);
        abort = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            abort = 1'b0;
            if (ftw_valid) after++;
            if (done) begin
                done_idx = k;
                ampl_done = ampl_out;
                break;
            end
        end
        check("abort_no_step", after, 0);
        check("abort_done_cycle", done_idx, ramp_len(256));
        check("abort_ampl", ampl_done, 0);
        @(negedge clk);
        check("abort_busy", busy, 0);
        cfg_loop = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        vecs[0] = '{32'h1000_0000, 32'h0100_0000, 16'd3, 24'd10, 16'd1024, 32'h1100_0000, 32'h1300_0000};
        vecs[1] = '{32'hFF00_0000, 32'h0200_0000, 16'd1, 24'd3,  16'd1024, 32'h0100_0000, 32'h0100_0000};
        vecs[2] = '{32'h0000_0100, 32'hFFFF_FF00, 16'd1, 24'd2,  16'd300,  32'h0000_0000, 32'h0000_0000};
        vecs[3] = '{32'h0000_4000, 32'h0000_0010, 16'd2, 24'd0,  16'd1024, 32'h0000_4010, 32'h0000_4020};
        vecs[4] = '{32'hABCD_0000, 32'h0000_0001, 16'd0, 24'd5,  16'd0,    32'h0000_0000, 32'hABCD_0000};

        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_ftw", ftw_out, 0);
        check("reset_pulses", {ftw_valid, phase_clr}, 0);
        check("reset_ampl", ampl_out, 0);
        check("reset_step_idx", step_idx, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        set_cfg(vecs[0], 1'b0);
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (busy || ftw_valid || phase_clr) bad++;
        end
        check("start_abort_idle", bad, 0);

        run_loop_abort();

        set_cfg(vecs[0], 1'b0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        check("pre_reset_busy", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_ftw", ftw_out, 0);
        check("midreset_ampl", ampl_out, 0);
        check("midreset_step_idx", step_idx, 0);
        check("midreset_pulses", {done, ftw_valid, phase_clr}, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        run_vec(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
